// File: rtl/pwm_deadtime.sv
// Complementary gate driver: turns a single PWM stream into a high/low-side pair with
// programmable dead time, per-side polarity, global enable and a latching break input.
module pwm_deadtime #(
  parameter int unsigned DT_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            pwm_in,
  input  logic [DT_W-1:0] dead_time,
  input  logic            pol_h,
  input  logic            pol_l,
  input  logic            brk,
  input  logic            brk_clr,
  output logic            out_h,
  output logic            out_l,
  output logic            dt_active,
  output logic            brk_flag
);

  typedef enum logic [2:0] {StIdle, StDtH, StHOn, StDtL, StLOn, StBrk} state_e;

  state_e            state_q, state_d;
  logic [DT_W-1:0]   cnt_q, cnt_d;
  logic              pwm_q, brk_q;
  logic              h_act_q, l_act_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (brk_q) begin
      state_d = StBrk;
    end else if (state_q == StBrk) begin
      // Fault stays latched until explicitly cleared; enable has no say here.
      if (brk_clr) state_d = StIdle;
    end else if (!en) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = pwm_q ? StDtH : StDtL;
          cnt_d   = dead_time;
        end
        StDtH: begin
          if (!pwm_q) begin
            state_d = StDtL;
            cnt_d   = dead_time;
          end else if (cnt_q == '0) begin
            state_d = StHOn;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        StDtL: begin
          if (pwm_q) begin
            state_d = StDtH;
            cnt_d   = dead_time;
          end else if (cnt_q == '0) begin
            state_d = StLOn;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        StHOn: begin
          if (!pwm_q) begin
            state_d = StDtL;
            cnt_d   = dead_time;
          end
        end
        StLOn: begin
          if (pwm_q) begin
            state_d = StDtH;
            cnt_d   = dead_time;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Activity flags follow the next state so the gate drives change on the same edge as the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pwm_q   <= 1'b0;
      brk_q   <= 1'b0;
      h_act_q <= 1'b0;
      l_act_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pwm_q   <= pwm_in;
      brk_q   <= brk;
      h_act_q <= (state_d == StHOn);
      l_act_q <= (state_d == StLOn);
    end
  end

  assign out_h     = h_act_q ^ pol_h;
  assign out_l     = l_act_q ^ pol_l;
  assign dt_active = (state_q == StDtH) || (state_q == StDtL);
  assign brk_flag  = (state_q == StBrk);

endmodule

// File: doc/pwm_deadtime.md
Name: pwm_deadtime

Overview:
- Complementary output stage that sits directly downstream of the timer and consumes its PWM output (out_p_1).
- Produces a high-side/low-side gate pair with programmable dead time between them, per-output polarity, a global enable and a latching break (fault) input.
- Guarantees that both sides are never active in the same cycle, regardless of input glitches or register changes.

Parameters:
- DT_W, 8, width of the dead-time count and of the internal down-counter.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- en  input  1  output enable; 0 forces both outputs inactive and the FSM to IDLE
- pwm_in  input  1  raw PWM from the timer (1 = high side requested, 0 = low side requested)
- dead_time  input  DT_W  dead-time count; both-off interval = dead_time+1 clk cycles
- pol_h  input  1  high-side polarity (0 = active-high, 1 = active-low)
- pol_l  input  1  low-side polarity (0 = active-high, 1 = active-low)
- brk  input  1  break/fault request, active-high
- brk_clr  input  1  break clear request, active-high
- out_h  output  1  high-side gate drive
- out_l  output  1  low-side gate drive
- dt_active  output  1  1 while the FSM is in a dead-time state
- brk_flag  output  1  1 while the FSM is in BRK (latched fault)

Behaviour:
- Reset is asynchronous and active-high on rst; the clock is clk.
- Input registers:
  - pwm_in is registered once into pwm_q.
  - brk is registered once into brk_q.
  - All decisions use pwm_q and brk_q.
- Output path:
  - Internal logical registers h_act and l_act are updated from the next state, so outputs are glitch-free.
  - out_h = h_act XOR pol_h; out_l = l_act XOR pol_l. Polarity is applied combinationally.
- Reset values:
  - State = IDLE; counter = 0; pwm_q = 0; brk_q = 0; h_act = 0; l_act = 0.
  - Therefore out_h = pol_h, out_l = pol_l, dt_active = 0, brk_flag = 0.
- FSM states: IDLE, DT_H, H_ON, DT_L, L_ON, BRK.
- Next-state priority each cycle, evaluated in this order:
  1. brk_q=1 -> BRK.
  2. Else en=0 -> IDLE.
  3. Else the transitions below.
- IDLE: both inactive. With en=1: pwm_q=1 -> DT_H; pwm_q=0 -> DT_L. Entry to any DT state loads counter <= dead_time.
- DT_H: both inactive; dt_active=1.
  - pwm_q=0 -> DT_L, counter reloaded with dead_time.
  - Else counter==0 -> H_ON.
  - Else counter decrements.
- DT_L: mirror of DT_H.
  - pwm_q=1 -> DT_H with reload.
  - Else counter==0 -> L_ON.
  - Else counter decrements.
- H_ON: h_act=1, l_act=0. pwm_q=0 -> DT_L (h_act cleared on the same edge, counter loaded).
- L_ON: l_act=1, h_act=0. pwm_q=1 -> DT_H.
- BRK: both inactive; brk_flag=1.
  - Exits to IDLE only when brk_clr=1 and brk_q=0.
  - brk dominates brk_clr when both are asserted; en is ignored while in BRK.
- Timing:
  - pwm_in edge sampled at clk edge k -> active side goes inactive at edge k+1.
  - Opposite side goes active at edge k+1+dead_time+1.
- dead_time is sampled only at DT entry; changes mid-interval take effect at the next DT entry.
- dead_time=0 still gives exactly 1 both-off cycle. Maximum is 2^DT_W cycles.
- pwm_in pulses shorter than the dead-time interval never drive either output active; the interval restarts on each toggle.
- Counter never wraps: it is only decremented when non-zero.
- Invariant: h_act & l_act == 0 in every cycle, including transitions into and out of IDLE/BRK and changes of en.
- rst mid-operation: outputs return to inactive levels immediately (asynchronously), and the FSM returns to IDLE.

Test Plan:
- Reset, pol_h=0, pol_l=1, en=0 -> out_h=0, out_l=1, dt_active=0, brk_flag=0; stays so while en=0 regardless of pwm_in.
- en=1, dead_time=3, pwm_in toggling with 20-cycle period -> each edge: old side off 1 cycle after sample, 4 cycles both-off with dt_active=1, new side on; assert h_act&l_act never 1.
- dead_time=0, pwm_in toggling every 5 cycles -> exactly 1 both-off cycle per transition.
- dead_time=5, steady L_ON, pwm_in high for 2 cycles then low -> out_h never active; DT_H then DT_L reload; out_l active again after 6 both-off cycles counted from the falling sample.
- In H_ON, pulse brk 1 cycle -> both inactive 1 cycle after sample, brk_flag=1 held. brk_clr with brk=1 -> stays BRK. brk_clr with brk=0 -> IDLE, then DT_x, then ON.
- Change dead_time 2->7 mid DT_L -> current interval stays 3 cycles; next transition uses 8 cycles. Assert rst during H_ON -> out_h inactive immediately, no clock needed.
